// File: rtl/alu_sequencer.sv
// Front-end scheduler: buffers 8-bit instructions in a small FIFO and issues them
// one at a time to the decode unit, spacing issues by each op's execution latency.
module alu_sequencer #(
    parameter int DEPTH    = 4,
    parameter int EXEC_LAT = 2,
    parameter int WR_LAT   = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_instr,
    output logic             in_ready,
    input  logic             hold,
    input  logic             clr_err,
    output logic             load,
    output logic [7:0]       instruction,
    output logic             busy,
    output logic             idle,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LAT_MAX = (EXEC_LAT > WR_LAT) ? EXEC_LAT : WR_LAT;
    localparam int WCNT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [WCNT_W-1:0] EXEC_WAIT = WCNT_W'(EXEC_LAT - 1);
    localparam logic [WCNT_W-1:0] WR_WAIT   = WCNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [WCNT_W-1:0] wait_cnt;

    logic       push, pop, head_illegal;
    logic [7:0] head;

    assign in_ready     = (count != FIFO_FULL);
    assign push         = in_valid && in_ready;
    assign pop          = (state == S_IDLE) && (count != '0) && !hold;
    assign head         = mem[rd_ptr];
    assign head_illegal = (head[7:5] == 3'b111);

    assign load = (state == S_ISSUE);
    assign busy = (state != S_IDLE);
    assign idle = (state == S_IDLE) && (count == '0);

    // Storage is not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop && !head_illegal) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instruction <= '0;
            wait_cnt    <= '0;
            issue_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop && !head_illegal) begin
                instruction <= head;
            end
            if (state == S_ISSUE) begin
                wait_cnt    <= (instruction[7:5] == 3'b110) ? WR_WAIT : EXEC_WAIT;
                issue_count <= issue_count + 1'b1;
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            // A reserved-opcode pop outranks a simultaneous clear.
            if (pop && head_illegal) begin
                illegal <= 1'b1;
            end else if (clr_err) begin
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a queue-based scheduling model checked every
// cycle, plus hand-computed expectations for issue order, spacing and counters.
module tb_alu_sequencer;

    localparam int DEPTH    = 4;
    localparam int EXEC_LAT = 2;
    localparam int WR_LAT   = 1;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_instr = 8'h00;
    logic             hold = 1'b0;
    logic             clr_err = 1'b0;
    logic             in_ready, load, busy, idle, illegal;
    logic [7:0]       instruction;
    logic [CNT_W-1:0] issue_count;

    alu_sequencer #(
        .DEPTH   (DEPTH),
        .EXEC_LAT(EXEC_LAT),
        .WR_LAT  (WR_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .hold       (hold),
        .clr_err    (clr_err),
        .load       (load),
        .instruction(instruction),
        .busy       (busy),
        .idle       (idle),
        .illegal    (illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model: a queue of accepted instructions and a countdown of busy cycles
    // remaining for the op currently in execution.
    logic [7:0]       mq[$];
    int               m_busy_left = 0;
    logic             m_load = 1'b0;
    logic [7:0]       m_instr = 8'h00;
    logic             m_illegal = 1'b0;
    logic [CNT_W-1:0] m_count = '0;

    always @(posedge clk or posedge rst) begin
        logic       can_pop, acc, set_ill;
        logic [7:0] h;
        if (rst) begin
            mq.delete();
            m_busy_left = 0;
            m_load      = 1'b0;
            m_instr     = 8'h00;
            m_illegal   = 1'b0;
            m_count     = '0;
        end else begin
            acc     = in_valid && (mq.size() < DEPTH);
            can_pop = (m_busy_left == 0) && (mq.size() != 0) && !hold;
            if (m_load) m_count = m_count + 1'b1;
            m_load  = 1'b0;
            set_ill = 1'b0;
            if (m_busy_left > 0) m_busy_left--;
            if (can_pop) begin
                h = mq.pop_front();
                if (h[7:5] == 3'b111) begin
                    set_ill = 1'b1;
                end else begin
                    m_instr     = h;
                    m_load      = 1'b1;
                    m_busy_left = 1 + ((h[7:5] == 3'b110) ? WR_LAT : EXEC_LAT);
                end
            end
            if (set_ill) m_illegal = 1'b1;
            else if (clr_err) m_illegal = 1'b0;
            if (acc) mq.push_back(in_instr);
        end
    end

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] ld_instr[$];
    int         ld_cyc[$];
    int         busy_cycles = 0;
    int         push_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        ld_instr.delete();
        ld_cyc.delete();
        busy_cycles = 0;
    endtask

    // One clock: compare against the model at the falling edge, then return
    // just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            check("load", load, m_load);
            check("instruction", instruction, m_instr);
            check("busy", busy, m_busy_left > 0);
            check("idle", idle, (m_busy_left == 0) && (mq.size() == 0));
            check("in_ready", in_ready, mq.size() < DEPTH);
            check("illegal", illegal, m_illegal);
            check("issue_count", issue_count, m_count);
            if (load) begin
                ld_instr.push_back(instruction);
                ld_cyc.push_back(cyc);
            end
            if (busy) busy_cycles++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int   n;
        logic ok;
        n = 0;
        in_valid = 1'b1;
        in_instr = b;
        do begin
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        check("push_accept", ok, 1'b1);
        push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(idle && !busy) && n < 600) begin
            tick();
            n++;
        end
        check("wait_idle", idle, 1'b1);
        tick();
    endtask

    initial begin
        int pc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("rst_load", load, 1'b0);
        check("rst_instruction", instruction, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_illegal", illegal, 1'b0);
        check("rst_issue_count", issue_count, 0);

        // Single op-000 issue
        clear_logs();
        push(8'h0A);
        pc = push_cyc;
        wait_idle();
        check("t1_loads", ld_instr.size(), 1);
        if (ld_instr.size() >= 1) begin
            check("t1_instr", ld_instr[0], 8'h0A);
            check("t1_latency", ld_cyc[0] - pc, 1);
        end
        check("t1_busy_cycles", busy_cycles, 3);
        check("t1_issue_count", issue_count, 1);

        // Register-write op followed by an ALU op
        clear_logs();
        push(8'hD5);
        push(8'h21);
        wait_idle();
        check("t2_loads", ld_instr.size(), 2);
        if (ld_instr.size() >= 2) begin
            check("t2_first", ld_instr[0], 8'hD5);
            check("t2_second", ld_instr[1], 8'h21);
            check("t2_spacing", ld_cyc[1] - ld_cyc[0], 3);
        end
        check("t2_issue_count", issue_count, 3);

        // Fill under hold, refuse the fifth, then drain in order
        clear_logs();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        in_valid = 1'b1;
        in_instr = 8'h05;
        repeat (3) tick();
        check("t3_full_ready", in_ready, 1'b0);
        check("t3_no_load_in_hold", ld_instr.size(), 0);
        in_valid = 1'b0;
        hold = 1'b0;
        wait_idle();
        check("t3_loads", ld_instr.size(), 4);
        if (ld_instr.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", ld_instr[i], 8'(i + 1));
            for (int i = 1; i < 4; i++) check("t3_spacing", ld_cyc[i] - ld_cyc[i-1], 4);
        end
        check("t3_issue_count", issue_count, 7);

        // Reserved opcode dropped, sticky flag, clear, and set-beats-clear
        clear_logs();
        push(8'hE3);
        push(8'h10);
        wait_idle();
        check("t4_illegal_set", illegal, 1'b1);
        check("t4_loads", ld_instr.size(), 1);
        if (ld_instr.size() >= 1) check("t4_instr", ld_instr[0], 8'h10);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        check("t4_illegal_clr", illegal, 1'b0);
        clr_err = 1'b1;
        push(8'hE3);
        tick();
        check("t4_set_wins", illegal, 1'b1);
        tick();
        check("t4_clr_after", illegal, 1'b0);
        clr_err = 1'b0;
        tick();

        // Asynchronous reset while waiting with two entries queued
        clear_logs();
        push(8'h0A);
        push(8'h01);
        push(8'h02);
        check("t5_pre_busy", busy, 1'b1);
        check("t5_pre_load", load, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_load", load, 1'b0);
        check("t5_instruction", instruction, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_idle", idle, 1'b1);
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_illegal", illegal, 1'b0);
        check("t5_issue_count", issue_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        repeat (10) tick();
        check("t5_no_load", ld_instr.size(), 0);
        check("t5_idle_after", idle, 1'b1);

        // Counter wrap after 256 issues
        clear_logs();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = {((i % 3) == 0) ? 3'b110 : 3'b010, 5'(i)};
            push(b);
        end
        wait_idle();
        check("t6_loads", ld_instr.size(), 256);
        check("t6_wrap", issue_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
